uart_com_fifo: RTL
==================

# uart_com_fifo

Byte-buffering bridge between the `uart` block's communication-mode port and core 0. It captures every `uart_rec_valid` pulse into an RX FIFO, and drains a core-written TX FIFO into `uart_send_req`/`uart_send_data`. This gives core 0 the flow control and overflow visibility that the raw UART port lacks.

## Interface

- `DEPTH_LOG2`, default 4, log2 of each FIFO depth (16 entries each).
- `clk`  in  1  system clock, all logic on rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `uart_rec_valid`  in  1  one-cycle pulse from `uart`: `uart_rec_data` is valid.
- `uart_rec_data`  in  8  received byte.
- `uart_send_ready`  in  1  `uart` transmitter idle.
- `uart_send_req`  out  1  one-cycle transmit request to `uart`.
- `uart_send_data`  out  8  byte to transmit; valid while `uart_send_req` is high.
- `com_rx_rd`  in  1  core pops the RX head.
- `com_rx_data`  out  8  RX head byte (show-ahead).
- `com_rx_empty`  out  1  RX FIFO empty.
- `com_rx_count`  out  DEPTH_LOG2+1  RX occupancy.
- `com_tx_wr`  in  1  core pushes `com_tx_wdata`.
- `com_tx_wdata`  in  8  byte to queue.
- `com_tx_full`  out  1  TX FIFO full.
- `com_tx_count`  out  DEPTH_LOG2+1  TX occupancy.
- `com_ovf`  out  2  sticky overflow flags: bit0 RX, bit1 TX.
- `com_ovf_clr`  in  2  per-bit clear of `com_ovf`.

## Operation

**FIFOs**
- Two independent circular buffers of 2^DEPTH_LOG2 × 8 bits.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
- Counts are DEPTH_LOG2+1 bits; full is count == 2^DEPTH_LOG2.

**RX path**
- Push on `uart_rec_valid`; pop on `com_rx_rd`.
- Push while full: byte dropped, `com_ovf[0]` set.
- Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
- Pop while empty: ignored, pointers and count unchanged.
- `com_rx_data` = mem[rd_ptr]; it is meaningful only while `com_rx_empty` = 0.

**TX path, core side**
- Push on `com_tx_wr`.
- Push while full and no internal pop in the same cycle: byte dropped, `com_ovf[1]` set.

**TX sender state machine**
- IDLE: if TX not empty and `uart_send_ready` = 1, register `uart_send_req` <= 1, register `uart_send_data` <= TX head, pop TX, go REQ.
- REQ: `uart_send_req` is high for exactly this cycle; clear it; go HOLD.
- HOLD: one cycle, allowing `uart_send_ready` to fall; go DRAIN.
- DRAIN: wait until `uart_send_ready` = 1, then go IDLE.

**Overflow flags**
- A set and a clear on the same flag in the same cycle: set wins.

**System rule**
- `uart` gives its internal echo/readback traffic priority over `uart_send_req`. Core 0 must not queue TX bytes while `uart` is in programming or readback mode. The block does not detect a preempted byte.

## Timing

- Reset (`rstn` = 0 at a clock edge) drives:
  - state = IDLE;
  - `uart_send_req` = 0, `uart_send_data` = 0;
  - all pointers and counts = 0;
  - `com_rx_empty` = 1, `com_tx_full` = 0, `com_ovf` = 0;
  - all memory entries = 0, so `com_rx_data` = 0.
- Reset mid-transmission: any queued bytes are lost. The byte already inside `uart` completes there. After reset, IDLE again waits for `uart_send_ready` before the next request.
- RX latency: `uart_rec_valid` at edge t means `com_rx_empty` = 0 and `com_rx_data` = byte after edge t.
- TX latency: `com_tx_wr` at edge t into an empty FIFO with ready = 1:
  - state IDLE at t+1;
  - `uart_send_req` high after edge t+2 for one cycle;
  - count returns to 0 after edge t+2.
- Minimum spacing between requests is REQ + HOLD + DRAIN ≥ 3 cycles. In practice it is a full UART frame, 10×(RS232_BIT_CYCLES+1) cycles.
- Counts update the cycle after the push/pop edge; simultaneous push and pop leave the count unchanged.
- Pointer wrap from 2^DEPTH_LOG2−1 to 0 requires no special handling.

## Test plan

- **RX basic:** 3 pulses carrying 0x41, 0x42, 0x43 → `com_rx_count` = 3, head = 0x41. Three `com_rx_rd` pops return 0x41, 0x42, 0x43, then `com_rx_empty` = 1.
- **RX overflow:** 17 pulses with no reads → count = 16, `com_ovf[0]` = 1, 17th byte absent. Simultaneous set and clear on the 18th pulse → flag stays 1. Clear alone → 0.
- **TX flow control:** push 0x55, 0xAA with ready modelled as `uart` (low for 370 cycles after each request) → exactly two one-cycle requests with data 0x55 then 0xAA, never while ready = 0.
- **Wrap and full:** push/pop 40 bytes through each FIFO with interleaved simultaneous push and pop at count 16 → data order preserved, no overflow flag.
- **Reset mid-DRAIN:** assert `rstn` low one cycle with 5 bytes queued → all outputs at reset values; next request only after ready = 1 and a new push.

Source files
------------

// File: rtl/uart_com_fifo.sv
// uart_com_fifo: RX and TX byte FIFOs between the uart comm-mode port and core 0, plus a paced TX sender.
// Latency: an RX byte is visible 1 cycle after uart_rec_valid; a TX request follows 2 cycles after com_tx_wr into an empty FIFO.
// Backpressure: none upstream; a push into a full FIFO drops the byte and sets a sticky com_ovf bit; the sender waits on uart_send_ready.
//
// Ports:
//   clk, rstn                            clock, synchronous active-low reset
//   uart_rec_valid, uart_rec_data        received byte strobe from uart
//   uart_send_ready                      uart transmitter idle
//   uart_send_req, uart_send_data        one-cycle transmit request and its byte
//   com_rx_rd, com_rx_data               core pop and show-ahead head byte
//   com_rx_empty, com_rx_count           RX status
//   com_tx_wr, com_tx_wdata              core push into TX FIFO
//   com_tx_full, com_tx_count            TX status
//   com_ovf, com_ovf_clr                 sticky overflow flags (bit0 RX, bit1 TX) and per-bit clear

module uart_com_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  uart_rec_valid,
  input  logic [7:0]            uart_rec_data,
  input  logic                  uart_send_ready,
  output logic                  uart_send_req,
  output logic [7:0]            uart_send_data,
  input  logic                  com_rx_rd,
  output logic [7:0]            com_rx_data,
  output logic                  com_rx_empty,
  output logic [DEPTH_LOG2:0]   com_rx_count,
  input  logic                  com_tx_wr,
  input  logic [7:0]            com_tx_wdata,
  output logic                  com_tx_full,
  output logic [DEPTH_LOG2:0]   com_tx_count,
  output logic [1:0]            com_ovf,
  input  logic [1:0]            com_ovf_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN
  } state_t;

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]            rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr;
  logic [DEPTH_LOG2-1:0] rx_rd_ptr;
  logic [DEPTH_LOG2:0]   rx_cnt;
  logic                  rx_full;
  logic                  rx_empty;
  logic                  rx_push;
  logic                  rx_pop;
  logic                  rx_ovf_set;

  assign rx_empty   = (rx_cnt == '0);
  assign rx_full    = (rx_cnt == FULL_CNT);
  assign rx_pop     = com_rx_rd && !rx_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign rx_push    = uart_rec_valid && (!rx_full || rx_pop);
  assign rx_ovf_set = uart_rec_valid && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rx_mem[i] <= '0;
      end
    end else begin
      if (rx_push) begin
        rx_mem[rx_wr_ptr] <= uart_rec_data;
        rx_wr_ptr         <= rx_wr_ptr + 1'b1;
      end
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + 1'b1;
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  assign com_rx_data  = rx_mem[rx_rd_ptr];
  assign com_rx_empty = rx_empty;
  assign com_rx_count = rx_cnt;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr;
  logic [DEPTH_LOG2-1:0] tx_rd_ptr;
  logic [DEPTH_LOG2:0]   tx_cnt;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  tx_push;
  logic                  tx_pop;
  logic                  tx_ovf_set;
  logic                  tx_pending;

  assign tx_empty   = (tx_cnt == '0);
  assign tx_full    = (tx_cnt == FULL_CNT);
  assign tx_push    = com_tx_wr && (!tx_full || tx_pop);
  assign tx_ovf_set = com_tx_wr && tx_full && !tx_pop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_cnt     <= '0;
      tx_pending <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem[i] <= '0;
      end
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr_ptr] <= com_tx_wdata;
        tx_wr_ptr         <= tx_wr_ptr + 1'b1;
      end
      if (tx_pop) begin
        tx_rd_ptr <= tx_rd_ptr + 1'b1;
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
      // Registered copy of "TX not empty": the sender reacts one cycle after
      // the count changes, which keeps the FIFO count off the request path.
      // It can be stale right after a pop, but the sender is then busy in
      // REQ/HOLD/DRAIN for at least three cycles, long enough to settle.
      tx_pending <= (tx_cnt != '0);
    end
  end

  assign com_tx_full  = tx_full;
  assign com_tx_count = tx_cnt;

  // ---------------------------------------------------------------------------
  // TX sender
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_nx;
  logic       send_req_nx;
  logic [7:0] send_data_nx;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= S_IDLE;
      uart_send_req  <= 1'b0;
      uart_send_data <= '0;
    end else begin
      state          <= state_nx;
      uart_send_req  <= send_req_nx;
      uart_send_data <= send_data_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    send_req_nx  = 1'b0;
    send_data_nx = uart_send_data;
    tx_pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_pending && !tx_empty && uart_send_ready) begin
          send_req_nx  = 1'b1;
          send_data_nx = tx_mem[tx_rd_ptr];
          tx_pop       = 1'b1;
          state_nx     = S_REQ;
        end
      end
      S_REQ: begin
        state_nx = S_HOLD;
      end
      // One dead cycle so uart has time to drop uart_send_ready before DRAIN
      // starts watching it.
      S_HOLD: begin
        state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (uart_send_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sticky overflow flags; a set in the same cycle as a clear wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      com_ovf <= 2'b00;
    end else begin
      com_ovf <= (com_ovf & ~com_ovf_clr) | {tx_ovf_set, rx_ovf_set};
    end
  end

endmodule
